reg_file_32x32: RTL and testbench

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

---
 rtl/reg_file_32x32_pkg.sv | 28 ++
 rtl/reg_file_32x32_read_port.sv | 39 +++
 rtl/reg_file_32x32.sv | 99 +++++++++
 tb/tb_reg_file_32x32.sv | 129 ++++++++++++
 4 files changed

// File: rtl/reg_file_32x32_pkg.sv
// Shared CPU constants for the register file, write-destination mux and control unit.
// Register indices, default widths and the stack-pointer reset value live here.
package reg_file_32x32_pkg;

    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned CPU_ADDR_W = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 30;
    localparam int unsigned REG_RA   = 31;

    localparam logic [31:0] CPU_SP_RESET = 32'h0000_03FC;

    // Value a register takes while reset is held: only the stack pointer is non-zero.
    function automatic logic [CPU_DATA_W-1:0] reset_value(
        input int unsigned           idx,
        input logic [CPU_DATA_W-1:0] sp_value
    );
        logic [CPU_DATA_W-1:0] val;
        if (idx == REG_SP) begin
            val = sp_value;
        end else begin
            val = {CPU_DATA_W{1'b0}};
        end
        return val;
    endfunction

endpackage

// File: rtl/reg_file_32x32_read_port.sv
// One combinational read path of the register file. Index 0 is hard-wired to zero.
// With REG_FILE_BYPASS_EN defined, an in-flight write to the same index is forwarded.
module reg_file_read_port
    import reg_file_32x32_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef REG_FILE_BYPASS_EN
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] rd_data_s;

    // Select stored contents, forced zero for index 0, optionally overridden by the write bypass.
    always_comb begin
        rd_data_s = regs[rd_addr];
        if (rd_addr == ZERO_IDX) begin
            rd_data_s = {DATA_W{1'b0}};
`ifdef REG_FILE_BYPASS_EN
        end else if (byp_en && (byp_addr == rd_addr)) begin
            rd_data_s = byp_data;
`endif
        end else begin
            rd_data_s = regs[rd_addr];
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/reg_file_32x32.sv
// Two-read / one-write CPU register file: r0 reads zero, r30 (stack pointer) resets to SP_RESET.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter int unsigned        DATA_W   = CPU_DATA_W,
    parameter int unsigned        ADDR_W   = CPU_ADDR_W,
    parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(CPU_SP_RESET)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_busy
);

    localparam int unsigned       NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_busy_q;
    logic              wr_busy_d;
    logic              wr_live_s;

    // A write only counts when it targets a real register; r0 writes vanish.
    always_comb begin
        wr_live_s = wr_en && (wr_addr != ZERO_IDX);
    end

    // Next-state of the array and the one-cycle write-pending flag.
    always_comb begin
        regs_d    = regs_q;
        wr_busy_d = wr_live_s;
        if (wr_live_s) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // State registers; reset clears everything except the stack pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= DATA_W'(reset_value(i, CPU_DATA_W'(SP_RESET)));
            end
            wr_busy_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            wr_busy_q <= wr_busy_d;
        end
    end

    assign wr_busy = wr_busy_q;

`ifdef REG_FILE_BYPASS_EN
    logic byp_en_s;

    // Forwarding is suppressed while reset holds so reads show reset contents.
    always_comb begin
        byp_en_s = wr_live_s && rst_n;
    end
`endif

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .regs     (regs_q),
        .rd_addr  (rs_addr),
`ifdef REG_FILE_BYPASS_EN
        .byp_en   (byp_en_s),
        .byp_addr (wr_addr),
        .byp_data (wr_data),
`endif
        .rd_data  (rs_data)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .regs     (regs_q),
        .rd_addr  (rt_addr),
`ifdef REG_FILE_BYPASS_EN
        .byp_en   (byp_en_s),
        .byp_addr (wr_addr),
        .byp_data (wr_data),
`endif
        .rd_data  (rt_data)
    );

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT read ports and wr_busy.
module tb_reg_file_32x32;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] SP = 32'h0000_03FC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs_addr = 5'd0;
    logic [4:0]  rt_addr = 5'd0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_busy;

    typedef struct {
        string       name;
        logic [31:0] rs_exp;
        logic [31:0] rt_exp;
        logic        busy_exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    reg_file_32x32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_busy (wr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %08h expected %08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "rs_data", rs_data, e.rs_exp);
            chk(e.name, "rt_data", rt_data, e.rt_exp);
            chk(e.name, "wr_busy", {31'd0, wr_busy}, {31'd0, e.busy_exp});
        end
    end

    task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input string name, input logic [31:0] rs_e, input logic [31:0] rt_e,
                         input logic busy_e);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        rs_addr = rs;
        rt_addr = rt;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        e.name     = name;
        e.rs_exp   = rs_e;
        e.rt_exp   = rt_e;
        e.busy_exp = busy_e;
        sb_q.push_back(e);
    endtask

    initial begin
        apply(1'b0, 5'd0,  5'd30, 1'b0, 5'd0,  32'h0,          "rst_init",  32'h0, SP, 1'b0);
        apply(1'b0, 5'd31, 5'd1,  1'b0, 5'd0,  32'h0,          "rst_init2", 32'h0, 32'h0, 1'b0);
        apply(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, DB,             "wr31_same",
              BYP ? DB : 32'h0, BYP ? DB : 32'h0, 1'b0);
        apply(1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,          "rd31",      DB, DB, 1'b1);
        apply(1'b1, 5'd31, 5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF,  "wr0_same",  DB, 32'h0, 1'b0);
        apply(1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,          "rd0",       32'h0, 32'h0, 1'b0);
        apply(1'b1, 5'd5,  5'd5,  1'b1, 5'd5,  32'h1,          "wr5_old",
              BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 1'b0);
        apply(1'b1, 5'd5,  5'd5,  1'b1, 5'd5,  32'h2,          "rw5_same",
              BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 1'b1);
        apply(1'b1, 5'd5,  5'd5,  1'b0, 5'd0,  32'h0,          "rd5_new",   32'h2, 32'h2, 1'b1);
        apply(1'b1, 5'd7,  5'd5,  1'b1, 5'd7,  32'h1234_5678,  "wr7",
              BYP ? 32'h1234_5678 : 32'h0, 32'h2, 1'b0);
        apply(1'b1, 5'd7,  5'd7,  1'b0, 5'd7,  32'h55,         "we0_7",     32'h1234_5678, 32'h1234_5678, 1'b1);
        apply(1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,          "rd7",       32'h1234_5678, DB, 1'b0);
        apply(1'b1, 5'd1,  5'd2,  1'b1, 5'd12, 32'hAAAA_0001,  "b2b_a",     32'h0, 32'h0, 1'b0);
        apply(1'b1, 5'd12, 5'd12, 1'b1, 5'd12, 32'hBBBB_0002,  "b2b_b",
              BYP ? 32'hBBBB_0002 : 32'hAAAA_0001, BYP ? 32'hBBBB_0002 : 32'hAAAA_0001, 1'b1);
        apply(1'b1, 5'd12, 5'd5,  1'b0, 5'd0,  32'h0,          "b2b_rd",    32'hBBBB_0002, 32'h2, 1'b1);
        apply(1'b0, 5'd9,  5'd30, 1'b1, 5'd9,  32'hCAFE_F00D,  "rst_wr9",   32'h0, SP, 1'b0);
        apply(1'b0, 5'd31, 5'd5,  1'b0, 5'd0,  32'h0,          "rst_clr",   32'h0, 32'h0, 1'b0);
        apply(1'b1, 5'd9,  5'd30, 1'b1, 5'd30, 32'h100,        "post_rst_wr30",
              32'h0, BYP ? 32'h100 : SP, 1'b0);
        apply(1'b1, 5'd9,  5'd30, 1'b0, 5'd0,  32'h0,          "rd30",      32'h0, 32'h100, 1'b1);
        apply(1'b1, 5'd30, 5'd29, 1'b0, 5'd0,  32'h0,          "idle",      32'h100, 32'h0, 1'b0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
